bus_responder: RTL
==================

BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 SHALL have parameter MEM_LAT, default 4, memory access latency in cycles; legal range 1..15.
REQ-002 SHALL have parameter CNT_W, default 16, width of each statistics counter.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named exactly as in the ports below.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  LLC bus request present.
REQ-007 req_ready  output  1  responder can accept a request.
REQ-008 req_op  input  3  bus operation: NOBUSOP=0, READ=1, WRITE=2, INVALIDATE=3, RWIM=4.
REQ-009 req_addr  input  32  line address of the request.
REQ-010 snp_in  input  2  aggregated peer snoop result: NOHIT=0, HIT=1, HITM=2, NORESULT=3.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  LLC accepts the response.
REQ-013 rsp_snoop  output  2  snoop result returned to the LLC, using the snp_in encoding.
REQ-014 rsp_excl  output  1  LLC shall install the line EXCLUSIVE.
REQ-015 rsp_err  output  1  illegal operation.
REQ-016 rsp_addr  output  32  captured req_addr.
REQ-017 rd_cnt, wr_cnt, rwim_cnt, hitm_cnt  output  CNT_W each  statistics counters.

Function
REQ-018 SHALL implement the states IDLE, SNOOP, WB, MEM and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE.
REQ-020 A request SHALL be accepted on a clock edge where req_valid=1 and req_ready=1; req_op and req_addr SHALL be captured at that edge.
REQ-021 On acceptance, the next state SHALL be:
- READ, RWIM, INVALIDATE -> SNOOP
- WRITE -> MEM
- NOBUSOP or 5..7 -> RESP with rsp_err=1
REQ-022 SNOOP SHALL last exactly 1 cycle, and snp_in SHALL be sampled at its closing edge.
REQ-023 From SNOOP, transitions SHALL be:
- INVALIDATE -> RESP
- HITM -> WB
- otherwise -> MEM
REQ-024 WB (peer writeback) and MEM SHALL each last exactly MEM_LAT cycles, counted by a down-counter; WB SHALL be followed by MEM.
REQ-025 Leaving MEM SHALL go to RESP.
REQ-026 rsp_valid SHALL be 1 only in RESP and SHALL hold rsp_snoop, rsp_excl, rsp_err and rsp_addr stable until a rsp_valid and rsp_ready edge, which returns the FSM to IDLE.
REQ-027 rsp_snoop SHALL be:
- the sampled snp_in for READ, RWIM and INVALIDATE, with a sampled NORESULT mapped to NOHIT
- NORESULT for WRITE and illegal operations
REQ-028 rsp_excl SHALL be 1 only for READ with a sampled NOHIT.
REQ-029 Latency in cycles from the acceptance edge to the first rsp_valid cycle SHALL be:
- READ or RWIM: 1+MEM_LAT, or 1+2*MEM_LAT on HITM
- WRITE: MEM_LAT
- INVALIDATE: 1
- illegal: 0, i.e. RESP in the next cycle
REQ-030 The counters SHALL increment as follows:
- rd_cnt on READ acceptance
- wr_cnt on WRITE acceptance
- rwim_cnt on RWIM acceptance
- hitm_cnt when HITM is sampled in SNOOP
REQ-031 Every counter SHALL saturate at all-ones and never wrap.
REQ-032 A new request SHALL NOT be accepted in the same cycle as the response handshake; the earliest acceptance SHALL be the following IDLE cycle.
REQ-033 rsp_ready held at 0 SHALL stall the FSM in RESP indefinitely with no counter change.
REQ-034 req_valid asserted while not IDLE SHALL be ignored and SHALL NOT be captured.

Reset
REQ-035 rst_n=0 SHALL immediately, independent of clk, force:
- state to IDLE
- req_ready=1
- rsp_valid=0, rsp_snoop=NOHIT, rsp_excl=0, rsp_err=0, rsp_addr=0
- all counters to 0
- the latency down-counter to 0
REQ-036 Reset during any state, including mid-WB or mid-MEM, SHALL abort the operation without any response.
REQ-037 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-038 READ 0x0000_1000 with snp_in=NOHIT, MEM_LAT=4 -> rsp_valid in cycle 5, rsp_snoop=NOHIT, rsp_excl=1, rd_cnt=1.
REQ-039 RWIM with snp_in=HITM, MEM_LAT=4 -> rsp_valid in cycle 9, rsp_snoop=HITM, rsp_excl=0, rwim_cnt=1, hitm_cnt=1.
REQ-040 WRITE then INVALIDATE with snp_in=HIT, rsp_ready=1 throughout:
- WRITE -> rsp_valid in cycle 4, rsp_snoop=NORESULT
- INVALIDATE -> response 1 cycle after acceptance, rsp_snoop=HIT
- req_ready low while each is in flight
REQ-041 req_op=6 -> RESP in the next cycle with rsp_err=1, rsp_snoop=NORESULT, no counter change.
REQ-042 Hold rsp_ready=0 for 10 cycles in RESP -> outputs stable, req_ready=0; then rsp_ready=1 -> IDLE next cycle.
REQ-043 Assert rst_n=0 during MEM of a READ -> rsp_valid=0 and counters=0 immediately, no response after release; with rd_cnt preloaded to 0xFFFF by 65535 READs, a further READ leaves rd_cnt=0xFFFF.

Source files
------------

// File: rtl/bus_responder.sv
//------------------------------------------------------------------------------
// bus_responder : LLC bus-request responder with snoop, writeback, memory
//                 latency modelling and saturating statistics counters.
// Revision      : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bus_responder #(
   parameter int MEM_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [31:0]      req_addr,
   input  logic [1:0]       snp_in,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [1:0]       rsp_snoop,
   output logic             rsp_excl,
   output logic             rsp_err,
   output logic [31:0]      rsp_addr,
   output logic [CNT_W-1:0] rd_cnt,
   output logic [CNT_W-1:0] wr_cnt,
   output logic [CNT_W-1:0] rwim_cnt,
   output logic [CNT_W-1:0] hitm_cnt
);

   localparam logic [2:0] c_OP_READ  = 3'd1;
   localparam logic [2:0] c_OP_WRITE = 3'd2;
   localparam logic [2:0] c_OP_INV   = 3'd3;
   localparam logic [2:0] c_OP_RWIM  = 3'd4;

   localparam logic [1:0] c_SNP_NOHIT    = 2'd0;
   localparam logic [1:0] c_SNP_HITM     = 2'd2;
   localparam logic [1:0] c_SNP_NORESULT = 2'd3;

   localparam logic [3:0] c_LAT_LOAD = 4'(MEM_LAT - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SNOOP = 3'd1,
      ST_WB    = 3'd2,
      ST_MEM   = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   state_t     r_state;
   logic [2:0] r_op;
   logic [3:0] r_lat;
   logic [1:0] w_snp_mapped;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // A peer that gives no result is reported to the LLC as a plain miss.
   assign w_snp_mapped = (snp_in == c_SNP_NORESULT) ? c_SNP_NOHIT : snp_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_op      <= 3'd0;
         r_lat     <= 4'd0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_snoop <= c_SNP_NOHIT;
         rsp_excl  <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_addr  <= 32'd0;
         rd_cnt    <= '0;
         wr_cnt    <= '0;
         rwim_cnt  <= '0;
         hitm_cnt  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  r_op      <= req_op;
                  rsp_addr  <= req_addr;
                  rsp_excl  <= 1'b0;
                  rsp_err   <= 1'b0;
                  rsp_snoop <= c_SNP_NORESULT;
                  case (req_op)
                     c_OP_READ: begin
                        rd_cnt  <= sat_inc(rd_cnt);
                        r_state <= ST_SNOOP;
                     end
                     c_OP_RWIM: begin
                        rwim_cnt <= sat_inc(rwim_cnt);
                        r_state  <= ST_SNOOP;
                     end
                     c_OP_INV: begin
                        r_state <= ST_SNOOP;
                     end
                     c_OP_WRITE: begin
                        wr_cnt  <= sat_inc(wr_cnt);
                        r_lat   <= c_LAT_LOAD;
                        r_state <= ST_MEM;
                     end
                     default: begin
                        rsp_err   <= 1'b1;
                        rsp_valid <= 1'b1;
                        r_state   <= ST_RESP;
                     end
                  endcase
               end
            end
            ST_SNOOP: begin
               rsp_snoop <= w_snp_mapped;
               rsp_excl  <= (r_op == c_OP_READ) && (snp_in == c_SNP_NOHIT);
               if (snp_in == c_SNP_HITM) begin
                  hitm_cnt <= sat_inc(hitm_cnt);
               end
               if (r_op == c_OP_INV) begin
                  rsp_valid <= 1'b1;
                  r_state   <= ST_RESP;
               end else if (snp_in == c_SNP_HITM) begin
                  r_lat   <= c_LAT_LOAD;
                  r_state <= ST_WB;
               end else begin
                  r_lat   <= c_LAT_LOAD;
                  r_state <= ST_MEM;
               end
            end
            ST_WB: begin
               // Peer writeback completes before the memory access starts.
               if (r_lat == 4'd0) begin
                  r_lat   <= c_LAT_LOAD;
                  r_state <= ST_MEM;
               end else begin
                  r_lat <= r_lat - 4'd1;
               end
            end
            ST_MEM: begin
               if (r_lat == 4'd0) begin
                  rsp_valid <= 1'b1;
                  r_state   <= ST_RESP;
               end else begin
                  r_lat <= r_lat - 4'd1;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  r_state   <= ST_IDLE;
               end
            end
            default: begin
               rsp_valid <= 1'b0;
               req_ready <= 1'b1;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire
